// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned BYTE_BITS = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_START = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_GAP   = 2'd3
    } arb_state_e;

    function automatic int unsigned wordBits(input int unsigned dataByte);
        return dataByte * BYTE_BITS;
    endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational rotating-priority picker: first asserted request at or after ptr, wrapping.
module uart_rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      index
);

    always_comb begin
        int unsigned k;
        logic [IW-1:0] kIdx;
        valid = 1'b0;
        index = '0;
        k     = 0;
        kIdx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            kIdx = IW'(k);
            if (!valid && req[kIdx]) begin
                valid = 1'b1;
                index = kIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional watchdog on the txDone wait is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_BYTE      = 1,
    parameter  int unsigned NUM_REQ        = 4,
    parameter  int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned W              = wordBits(DATA_BYTE),
    localparam int unsigned IW             = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ*W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [NUM_REQ-1:0]   o_done,
    output logic [IW-1:0]        o_owner,
    output logic                 o_active,
    output logic                 o_txEn,
    output logic                 o_txStart,
    output logic [W-1:0]         o_tx_data,
    input  logic                 i_txDone,
    input  logic                 i_txBusy,
    output logic                 o_timeout
);

    localparam logic [1:0] StIdle  = ARB_IDLE;
    localparam logic [1:0] StStart = ARB_START;
    localparam logic [1:0] StWait  = ARB_WAIT;
    localparam logic [1:0] StGap   = ARB_GAP;

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES == 0) begin : gBadParams
        $error("uart_tx_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYCLES nonzero");
    end

    logic [1:0]    stateQ;
    logic [IW-1:0] ptrQ;
    logic [IW-1:0] nextPtr;
    logic          pickValid;
    logic [IW-1:0] pickIdx;
    logic          wdExpire;
    logic [W-1:0]  reqWords [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : gWords
        assign reqWords[k] = i_req_data[k*W +: W];
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) uPicker (
        .req   (i_req),
        .ptr   (ptrQ),
        .valid (pickValid),
        .index (pickIdx)
    );

    assign nextPtr = (pickIdx == IW'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wdCnt;
    logic          wdPulse;

    // Expiry is the WAIT cycle on which the counter would reach TIMEOUT_CYCLES.
    assign wdExpire = (stateQ == StWait) && !i_txDone && (wdCnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wdCnt   <= '0;
            wdPulse <= 1'b0;
        end else begin
            wdPulse <= wdExpire;
            if (stateQ == StStart) begin
                wdCnt <= '0;
            end else if (stateQ == StWait) begin
                wdCnt <= wdCnt + 1'b1;
            end
        end
    end

    assign o_timeout = wdPulse;
`else
    assign wdExpire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stateQ    <= StIdle;
            ptrQ      <= '0;
            o_grant   <= '0;
            o_done    <= '0;
            o_owner   <= '0;
            o_active  <= 1'b0;
            o_txEn    <= 1'b0;
            o_txStart <= 1'b0;
            o_tx_data <= '0;
        end else begin
            o_grant   <= '0;
            o_done    <= '0;
            o_txStart <= 1'b0;
            case (stateQ)
                StIdle: begin
                    if (pickValid && !i_txBusy) begin
                        o_grant   <= NUM_REQ'(1) << pickIdx;
                        o_tx_data <= reqWords[pickIdx];
                        o_owner   <= pickIdx;
                        o_txStart <= 1'b1;
                        o_txEn    <= 1'b1;
                        o_active  <= 1'b1;
                        ptrQ      <= nextPtr;
                        stateQ    <= StStart;
                    end
                end
                // txDone is not looked at here: it cannot belong to the word just started.
                StStart: stateQ <= StWait;
                StWait: begin
                    if (i_txDone) begin
                        o_done <= NUM_REQ'(1) << o_owner;
                        o_txEn <= 1'b0;
                        stateQ <= StGap;
                    end else if (wdExpire) begin
                        o_txEn <= 1'b0;
                        stateQ <= StGap;
                    end
                end
                StGap: begin
                    o_active <= 1'b0;
                    stateQ   <= StIdle;
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner sequences, random traffic.
module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic [1:0]     owner;
    logic           active;
    logic           txEn;
    logic           txStart;
    logic [W-1:0]   txData;
    logic           txDone;
    logic           txBusy;
    logic           timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_BYTE      (1),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_req_data (reqData),
        .o_grant    (grant),
        .o_done     (done),
        .o_owner    (owner),
        .o_active   (active),
        .o_txEn     (txEn),
        .o_txStart  (txStart),
        .o_tx_data  (txData),
        .i_txDone   (txDone),
        .i_txBusy   (txBusy),
        .o_timeout  (timeout)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          delay;
        logic [3:0]  expGrant;
        logic [7:0]  expData;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr(input int p, input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    function automatic int ohIdx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [21:0] allOut();
        return {grant, done, owner, active, txEn, txStart, txData, timeout};
    endfunction

    // Completes a transfer already in WAIT: waitTicks more cycles, then one txDone pulse.
    task automatic serve(input int waitTicks, input logic [3:0] expDone, input string tag);
        repeat (waitTicks) tick();
        txDone = 1'b1;
        tick();
        txDone = 1'b0;
        check({tag, "_done"}, 32'(done), 32'(expDone));
        check({tag, "_txEn_low"}, 32'(txEn), 0);
        check({tag, "_gap_active"}, 32'(active), 1);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 0);
        check({tag, "_idle"}, 32'(active), 0);
    endtask

    initial begin
        int waited;
        int cnt;
        int lastDoneEdge;
        int mPtr;
        int mOwner;
        int xAge;
        int doneAt;
        bit inXfer;

        vecs[0]  = '{4'b1111, 32'h44332211, 5, 4'b0001, 8'h11};
        vecs[1]  = '{4'b1111, 32'h44332211, 5, 4'b0010, 8'h22};
        vecs[2]  = '{4'b1111, 32'h44332211, 5, 4'b0100, 8'h33};
        vecs[3]  = '{4'b1111, 32'h44332211, 5, 4'b1000, 8'h44};
        vecs[4]  = '{4'b1111, 32'h44332211, 5, 4'b0001, 8'h11};
        vecs[5]  = '{4'b0100, 32'h44A52211, 10, 4'b0100, 8'hA5};
        vecs[6]  = '{4'b0001, 32'h44332211, 3, 4'b0001, 8'h11};
        vecs[7]  = '{4'b0001, 32'h443322C7, 2, 4'b0001, 8'hC7};
        vecs[8]  = '{4'b0110, 32'h44332211, 4, 4'b0010, 8'h22};
        vecs[9]  = '{4'b0101, 32'h44332211, 6, 4'b0100, 8'h33};
        vecs[10] = '{4'b1001, 32'h44332211, 2, 4'b1000, 8'h44};

        rst = 1'b1;
        req = '0;
        reqData = '0;
        txDone = 1'b0;
        txBusy = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'(allOut()), 0);
        rst = 1'b0;
        tick();
        check("post_reset_idle", 32'(allOut()), 0);

        for (int r = 0; r < 11; r++) begin
            req = vecs[r].req;
            reqData = vecs[r].data;
            waited = 0;
            do begin
                tick();
                waited++;
            end while (grant == '0 && waited < 20);
            check($sformatf("v%0d_grant_latency", r), waited, 1);
            check($sformatf("v%0d_grant", r), 32'(grant), 32'(vecs[r].expGrant));
            check($sformatf("v%0d_tx_data", r), 32'(txData), 32'(vecs[r].expData));
            check($sformatf("v%0d_owner", r), 32'(owner), ohIdx(vecs[r].expGrant));
            check($sformatf("v%0d_txStart", r), 32'(txStart), 1);
            req = '0;
            tick();
            check($sformatf("v%0d_start_pulse", r), 32'({grant, txStart}), 0);
            check($sformatf("v%0d_txEn_hold", r), 32'(txEn), 1);
            serve(vecs[r].delay - 2, vecs[r].expGrant, $sformatf("v%0d", r));
        end

        txBusy = 1'b1;
        req = 4'b0001;
        reqData = 32'h000000B2;
        cnt = 0;
        repeat (20) begin
            tick();
            if (grant != '0 || active) cnt++;
        end
        check("busy_no_grant", cnt, 0);
        txBusy = 1'b0;
        tick();
        check("busy_release_grant", 32'(grant), 32'b0001);
        check("busy_release_data", 32'(txData), 32'hB2);
        req = '0;
        tick();
        serve(2, 4'b0001, "busy");

        req = 4'b0001;
        reqData = 32'h0000773C;
        tick();
        check("hold_grant", 32'(grant), 32'b0001);
        req = 4'b0010;
        reqData = 32'h000077FF;
        cnt = 0;
        repeat (4) begin
            tick();
            if (txData !== 8'h3C || owner !== 2'd0 || grant != '0) cnt++;
        end
        check("hold_data_stable", cnt, 0);
        req = '0;
        serve(0, 4'b0001, "hold");
        cnt = 0;
        repeat (6) begin
            tick();
            if (grant != '0) cnt++;
        end
        check("withdrawn_never_granted", cnt, 0);

        req = 4'b0010;
        reqData = 32'h00005A00;
        tick();
        check("wd_grant", 32'(grant), 32'b0010);
`ifdef UART_ARB_TIMEOUT_EN
        req = 4'b0100;
        cnt = 0;
        repeat (16) begin
            tick();
            if (timeout || done != '0) cnt++;
        end
        check("wd_quiet_before_limit", cnt, 0);
        tick();
        check("wd_timeout_pulse", 32'(timeout), 1);
        check("wd_no_done", 32'(done), 0);
        check("wd_txEn_low", 32'(txEn), 0);
        tick();
        check("wd_timeout_drop", 32'(timeout), 0);
        check("wd_gap_no_grant", 32'(grant), 0);
        tick();
        check("wd_next_grant", 32'(grant), 32'b0100);
        req = '0;
        tick();
        serve(1, 4'b0100, "wd_next");
`else
        req = '0;
        cnt = 0;
        repeat (40) begin
            tick();
            if (!active || !txEn || timeout || done != '0) cnt++;
        end
        check("no_wd_stays_wait", cnt, 0);
        serve(0, 4'b0010, "no_wd");
`endif

        req = 4'b1111;
        tick();
        check("rst_mid_grant", 32'(grant != '0), 1);
        req = '0;
        repeat (2) tick();
        rst = 1'b1;
        txDone = 1'b1;
        #1;
        check("rst_async_outputs", 32'(allOut()), 0);
        tick();
        check("rst_no_done", 32'(allOut()), 0);
        rst = 1'b0;
        txDone = 1'b0;
        cnt = 0;
        repeat (5) begin
            tick();
            if (allOut() != '0) cnt++;
        end
        check("rst_release_quiet", cnt, 0);

        // Random traffic against a transaction-timing model: RR pointer, grant eligibility
        // (idle, two edges after the last done, not busy) and owner-specific completion.
        mPtr = 0;
        mOwner = 0;
        inXfer = 1'b0;
        xAge = 0;
        doneAt = 2;
        lastDoneEdge = -10;
        for (int e = 0; e < 800; e++) begin
            bit eligible;
            bit doneNow;
            int win;
            int age;
            logic [7:0] expData;
            logic [3:0] expDone;
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    reqData[k*W +: W] = 8'($urandom);
                end else if (req[k] && $urandom_range(0, 29) == 0) begin
                    req[k] = 1'b0;
                end
            end
            txBusy = ($urandom_range(0, 5) == 0);
            age = xAge + 1;
            txDone = inXfer && ((age == doneAt) || (age == 1 && $urandom_range(0, 3) == 0));
            eligible = !inXfer && (e - lastDoneEdge >= 2) && (req != '0) && !txBusy;
            win = rr(mPtr, req);
            expData = (win >= 0) ? reqData[win*W +: W] : 8'h00;
            doneNow = inXfer && age >= 2 && txDone;
            expDone = doneNow ? 4'(1 << mOwner) : 4'b0000;
            tick();
            if (inXfer) xAge++;
            if (doneNow) begin
                inXfer = 1'b0;
                lastDoneEdge = e;
            end
            if (eligible) begin
                inXfer = 1'b1;
                mOwner = win;
                mPtr = (win + 1) % N;
                xAge = 0;
                doneAt = $urandom_range(2, 9);
                req[win] = 1'b0;
            end
            check($sformatf("rnd%0d_grant", e), 32'(grant), eligible ? (1 << win) : 0);
            check($sformatf("rnd%0d_txStart", e), 32'(txStart), 32'(eligible));
            check($sformatf("rnd%0d_done", e), 32'(done), 32'(expDone));
            check($sformatf("rnd%0d_txEn", e), 32'(txEn), 32'(inXfer));
            check($sformatf("rnd%0d_active", e), 32'(active),
                  32'(inXfer || lastDoneEdge == e));
            check($sformatf("rnd%0d_timeout", e), 32'(timeout), 0);
            if (eligible) begin
                check($sformatf("rnd%0d_data", e), 32'(txData), 32'(expData));
                check($sformatf("rnd%0d_owner", e), 32'(owner), win);
            end
        end
        txDone = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
